ula_serial_ctrl: RTL and testbench

Bit-serial sequencer that sits directly upstream and downstream of the 1-bit top_ula. It accepts WIDTH-bit operands plus a 2-bit op, presents one bit per clock to top_ula LSB-first, and chains carryOut back into carryIn. It collects the C bits into a WIDTH-bit result and reports the final carry with a done pulse. The combinational top_ula is instantiated outside this block, and its ports connect to the ula_* ports below.

---
 rtl/ula_serial_ctrl.sv | 132 +++++++++++++
 tb/tb_ula_serial_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ula_serial_ctrl.sv
// Bit-serial sequencer around a 1-bit top_ula: feeds operand bits LSB-first,
// chains the carry between bit slices and gathers the serial result.
module ula_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             ula_A,
  output logic             ula_B,
  output logic             ula_carryIn,
  output logic [1:0]       ula_op,
  input  logic             ula_C,
  input  logic             ula_carryOut
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] aSh_r;
  logic [WIDTH-1:0] bSh_r;
  logic [WIDTH-2:0] resSh_r;
  logic [1:0]       op_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic             carryOut_r;
  logic [WIDTH-1:0] resFull_s;

  // Incoming result bit joined with the bits gathered so far (MSB = newest).
  assign resFull_s = {ula_C, resSh_r};

  // Sequencer FSM; operand/op/carry registers are zeroed outside RUN so the
  // ula_* outputs can come straight from registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      aSh_r      <= '0;
      bSh_r      <= '0;
      resSh_r    <= '0;
      op_r       <= 2'b00;
      carry_r    <= 1'b0;
      cnt_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      result_r   <= '0;
      carryOut_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            aSh_r   <= a_in;
            bSh_r   <= b_in;
            op_r    <= op_in;
            carry_r <= cin;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          resSh_r <= resFull_s[WIDTH-1:1];
          aSh_r   <= aSh_r >> 1;
          bSh_r   <= bSh_r >> 1;
          if (cnt_r == LAST_CNT) begin
            // Last slice: publish, and park cnt at zero instead of letting it wrap.
            result_r   <= resFull_s;
            carryOut_r <= ula_carryOut;
            carry_r    <= 1'b0;
            op_r       <= 2'b00;
            cnt_r      <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            state_r    <= DONE;
          end else begin
            carry_r <= ula_carryOut;
            cnt_r   <= cnt_r + CW'(1);
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          aSh_r   <= '0;
          bSh_r   <= '0;
          op_r    <= 2'b00;
          carry_r <= 1'b0;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign result      = result_r;
  assign carry_out   = carryOut_r;
  assign ula_A       = aSh_r[0];
  assign ula_B       = bSh_r[0];
  assign ula_carryIn = carry_r;
  assign ula_op      = op_r;

endmodule

// File: tb/tb_ula_serial_ctrl.sv
// Directed self-checking bench for ula_serial_ctrl with a behavioural 1-bit top_ula.
module tb_ula_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op_in = 2'b00;
  logic [7:0] a_in = 8'h00;
  logic [7:0] b_in = 8'h00;
  logic       cin = 1'b0;
  logic       busy, done, carry_out;
  logic [7:0] result;
  logic       ula_A, ula_B, ula_carryIn, ula_C, ula_carryOut;
  logic [1:0] ula_op;

  int checks = 0;
  int errors = 0;

  ula_serial_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_in(op_in),
    .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .ula_A(ula_A), .ula_B(ula_B), .ula_carryIn(ula_carryIn), .ula_op(ula_op),
    .ula_C(ula_C), .ula_carryOut(ula_carryOut)
  );

  // top_ula model: 00 AND, 01 OR, 10 XOR, 11 full-add (carry only for add)
  always_comb begin
    case (ula_op)
      2'b00: begin ula_C = ula_A & ula_B; ula_carryOut = 1'b0; end
      2'b01: begin ula_C = ula_A | ula_B; ula_carryOut = 1'b0; end
      2'b10: begin ula_C = ula_A ^ ula_B; ula_carryOut = 1'b0; end
      default: begin
        ula_C        = ula_A ^ ula_B ^ ula_carryIn;
        ula_carryOut = (ula_A & ula_B) | (ula_carryIn & (ula_A ^ ula_B));
      end
    endcase
  end

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    a_in = 8'($urandom);
    b_in = 8'($urandom);
    op_in = 2'b11;
    cin = 1'b1;
    repeat (3) step();
    checks++;
    if ({busy, done, carry_out} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got busy/done/cout=%b expected 000", {busy, done, carry_out});
    end
    checks++;
    if (result !== 8'h00) begin
      errors++; $display("FAIL reset_result: got %h expected 00", result);
    end
    checks++;
    if ({ula_A, ula_B, ula_carryIn, ula_op} !== 5'b00000) begin
      errors++; $display("FAIL reset_ula: got %b expected 00000", {ula_A, ula_B, ula_carryIn, ula_op});
    end
    start = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    a_in = 8'hA5; b_in = 8'h5B; cin = 1'b0; op_in = 2'b11; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL add_busy cycle %0d: got busy=%b done=%b expected 1 0", i, busy, done);
      end
      if (i == 1) begin
        checks++;
        if (ula_carryOut !== 1'b1) begin
          errors++; $display("FAIL add_c1_cout: got %b expected 1", ula_carryOut);
        end
      end
      if (i == 2) begin
        checks++;
        if (ula_carryIn !== 1'b1) begin
          errors++; $display("FAIL add_c2_cin: got %b expected 1", ula_carryIn);
        end
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL add_done: got done=%b busy=%b expected 1 0", done, busy);
    end
    checks++;
    if (result !== 8'h00 || carry_out !== 1'b1) begin
      errors++; $display("FAIL add_result: got %h/%b expected 00/1", result, carry_out);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL add_done_width: got done=%b expected 0", done);
    end
  endtask

  task automatic test_logic();
    logic [7:0] expv [3];
    expv[0] = 8'h30; expv[1] = 8'hFC; expv[2] = 8'hCC;
    for (int k = 0; k < 3; k++) begin
      a_in = 8'hF0; b_in = 8'h3C; cin = 1'b0; op_in = 2'(k); start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (ula_op !== 2'(k)) begin
        errors++; $display("FAIL logic_op %0d: got %b expected %b", k, ula_op, 2'(k));
      end
      for (int i = 1; i <= 8; i++) begin
        checks++;
        if (done !== 1'b0) begin
          errors++; $display("FAIL logic_early_done op %0d cycle %0d: got 1 expected 0", k, i);
        end
        step();
      end
      checks++;
      if (done !== 1'b1 || result !== expv[k]) begin
        errors++; $display("FAIL logic_result op %0d: got done=%b result=%h expected 1 %h", k, done, result, expv[k]);
      end
      step();
      checks++;
      if ({ula_A, ula_B, ula_carryIn, ula_op} !== 5'b00000) begin
        errors++; $display("FAIL logic_idle_ula op %0d: got %b expected 00000", k, {ula_A, ula_B, ula_carryIn, ula_op});
      end
    end
  endtask

  task automatic test_start_while_busy();
    int pulses = 0;
    logic [7:0] seenRes = 8'hXX;
    logic seenCout = 1'bx;
    a_in = 8'h01; b_in = 8'h01; cin = 1'b0; op_in = 2'b11; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    a_in = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        pulses++;
        seenRes = result;
        seenCout = carry_out;
      end
      step();
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL busy_pulses: got %0d expected 1", pulses);
    end
    checks++;
    if (seenRes !== 8'h02 || seenCout !== 1'b0) begin
      errors++; $display("FAIL busy_result: got %h/%b expected 02/0", seenRes, seenCout);
    end
  endtask

  task automatic test_back_to_back();
    int doneCycles [$];
    int pulses = 0;
    a_in = 8'hFF; b_in = 8'hFF; cin = 1'b0; op_in = 2'b11; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    checks++;
    if (ula_A !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL midop_pre: got ula_A=%b busy=%b expected 1 1", ula_A, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, carry_out, ula_A, ula_B, ula_carryIn, ula_op} !== 8'h00 || result !== 8'h00) begin
      errors++; $display("FAIL midop_reset: got flags=%b result=%h expected 0", {busy, done, carry_out, ula_A, ula_B, ula_carryIn, ula_op}, result);
    end
    for (int i = 0; i < 12; i++) begin
      if (done !== 1'b0) pulses++;
      step();
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL midop_no_done: got %0d pulses expected 0", pulses);
    end
    rst_n = 1'b1;
    a_in = 8'hFF; b_in = 8'h00; cin = 1'b1; op_in = 2'b11; start = 1'b1;
    for (int s = 1; s <= 40; s++) begin
      step();
      if (done === 1'b1) begin
        doneCycles.push_back(s);
        checks++;
        if (result !== 8'h00 || carry_out !== 1'b1) begin
          errors++; $display("FAIL b2b_result at step %0d: got %h/%b expected 00/1", s, result, carry_out);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (doneCycles.size() != 4) begin
      errors++; $display("FAIL b2b_count: got %0d pulses expected 4", doneCycles.size());
    end else begin
      checks++;
      if (doneCycles[0] != 9) begin
        errors++; $display("FAIL b2b_first: got step %0d expected 9", doneCycles[0]);
      end
      for (int j = 1; j < 4; j++) begin
        checks++;
        if (doneCycles[j] - doneCycles[j-1] != 10) begin
          errors++; $display("FAIL b2b_period %0d: got %0d expected 10", j, doneCycles[j] - doneCycles[j-1]);
        end
      end
    end
    repeat (12) step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_logic();
    test_start_while_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
